line_buf_arbiter: RTL and testbench
===================================

Name: line_buf_arbiter

Overview:
- Sequences the 512x8 camera line-buffer block RAM as two 256-byte ping-pong halves.
- The camera pixel path writes one half while the SPI readout side drains the other.
- Generates all EBR read/write addresses and enables, tracks which half holds a complete line, and flags dropped data.
- Lives in the pixel-clock domain; the readout side presents requests already synchronised to pclk.

Parameters:
- ADDR_W, 9, EBR address width; MSB selects the half.
- DATA_W, 8, pixel and EBR data width.
- HALF_DEPTH, 256, bytes per half; must equal 2**(ADDR_W-1).

Ports:
- pclk  in  1  single block clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel byte present this cycle.
- pix_data  in  DATA_W  pixel byte.
- hblank  in  1  one-cycle strobe: end of line.
- vblank  in  1  one-cycle strobe: start of frame.
- rd_req  in  1  readout requests next byte; may be asserted every cycle.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_W  byte read from EBR.
- line_ready  out  1  a complete line is available for readout.
- line_len  out  ADDR_W  byte count of the ready line (1..256); 0 when line_ready=0.
- overflow  out  1  sticky: pixels or a line were dropped this frame.
- ebr_waddr  out  ADDR_W  EBR write address.
- ebr_wdata  out  DATA_W  EBR write data.
- ebr_we  out  1  EBR write enable (drives both WE and WCLKE).
- ebr_raddr  out  ADDR_W  EBR read address.
- ebr_re  out  1  EBR read enable (drives both RE and RCLKE).
- ebr_rdata  in  DATA_W  EBR read data; valid 1 cycle after ebr_re.

Behaviour:
- Reset, asynchronous on rstn=0: all outputs 0; wr_half=0, rd_half=0, half_full=2'b00, wr_cnt=0, rd_cnt=0, write FSM=WRITE.
  - Reset mid-operation abandons every line.
  - No EBR enable is asserted on the first cycle after release.

Write FSM states are WRITE and STALL.
- WRITE with pix_valid at cycle N and wr_cnt<256:
  - At N+1: ebr_we=1, ebr_waddr={wr_half,wr_cnt[7:0]}, ebr_wdata=pix_data (registered).
  - wr_cnt increments (9 bits).
- WRITE with pix_valid and wr_cnt==256: byte dropped, no ebr_we, overflow<=1.
- hblank in WRITE with wr_cnt>0 (commit):
  - half_full[wr_half]<=1 and half_len[wr_half]<=wr_cnt.
  - wr_half toggles and wr_cnt<=0.
  - If registered half_full[~wr_half]==1 at that cycle, next state is STALL.
- hblank in WRITE with wr_cnt==0: no action.
- STALL:
  - All pixels are discarded; the first discarded pixel of each line sets overflow.
  - At each hblank, if registered half_full[wr_half]==0, go to WRITE. That hblank commits nothing; the following line is written.
- vblank:
  - wr_cnt<=0, discarding any partial line; committed halves are kept.
  - overflow<=0; vblank wins over a same-cycle overflow set.
  - State becomes WRITE if half_full[wr_half]==0, otherwise STALL.
- hblank and pix_valid in the same cycle: the pixel belongs to the ending line and is counted before the commit.

Read side:
- line_ready=half_full[rd_half] (registered).
- line_len=half_len[rd_half] when ready, else 0.
- rd_req at cycle N with line_ready=1:
  - At N+1: ebr_re=1, ebr_raddr={rd_half,rd_cnt[7:0]}, rd_cnt increments.
  - At N+2: rd_valid=1, rd_data=ebr_rdata.
  - Latency req→data is 2 cycles; throughput is 1 byte/cycle.
- rd_req with line_ready=0: ignored; no ebr_re and no rd_valid.
- Release on the request that makes rd_cnt==line_len: half_full[rd_half]<=0 at N+1, rd_half toggles, rd_cnt<=0. line_ready reflects the next half from N+1.
- Commit of one half and release of the other in the same cycle: both take effect.
- A STALL check reads half_full before a same-cycle release.
- Write and read never target the same half, so no EBR address collision is possible.

Test Plan:
- Ten pixels 0x01..0x0A then hblank → line_ready=1, line_len=10. Ten back-to-back rd_req → ebr_raddr 0..9, rd_data 01..0A on consecutive cycles starting 2 cycles after the first req; line_ready=0 the cycle after the 10th req.
- One 300-pixel line then hblank → ebr_we pulses exactly 256 times (waddr 0..255), overflow=1, line_len=256. Readout of 256 bytes returns the first 256 pixels.
- Three lines (A=4, B=5, C=6 bytes) with no reads → A in half 0 and B in half 1, C dropped, overflow=1. Read 4 bytes → A returned, then line_ready=1, line_len=5. Read 5 → B. Line D written after the next hblank lands at waddr 0x000.
- Five pixels, vblank, then three pixels and hblank → line_len=3 at ebr_waddr 0..2; overflow cleared by vblank.
- rd_req held high with line_ready=0 for 10 cycles → ebr_re=0, rd_valid=0 throughout.
- rstn pulsed low mid-read with both halves full → all outputs 0 within the reset cycle; after release, line_ready=0 and the next line writes at waddr 0x000.

Source files
------------

// File: rtl/line_buf_arbiter.sv
// Ping-pong sequencer for the 512x8 camera line-buffer EBR: pixels fill one 256-byte half
// while the readout side drains the other. Single pclk domain.
module line_buf_arbiter #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned HALF_DEPTH = 256
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              line_ready,
    output logic [ADDR_W-1:0] line_len,
    output logic              overflow,
    output logic [ADDR_W-1:0] ebr_waddr,
    output logic [DATA_W-1:0] ebr_wdata,
    output logic              ebr_we,
    output logic [ADDR_W-1:0] ebr_raddr,
    output logic              ebr_re,
    input  logic [DATA_W-1:0] ebr_rdata
);

    localparam logic [ADDR_W-1:0] FullCnt = ADDR_W'(HALF_DEPTH);

    typedef enum logic {StWrite, StStall} wrState_e;

    wrState_e          wrState;
    logic              wrHalf;
    logic              rdHalf;
    logic [1:0]        halfFull;
    logic [ADDR_W-1:0] halfLen [2];
    logic [ADDR_W-1:0] wrCnt;
    logic [ADDR_W-1:0] rdCnt;

    logic              pixAccept;
    logic [ADDR_W-1:0] lineCnt;
    logic              commit;
    logic              rdFire;
    logic [ADDR_W-1:0] rdNext;
    logic              rdRelease;

    always_comb begin
        pixAccept = (wrState == StWrite) && !vblank && pix_valid && (wrCnt != FullCnt);
        // A pixel arriving with hblank belongs to the line being closed.
        lineCnt   = wrCnt + ADDR_W'(pixAccept);
        commit    = (wrState == StWrite) && !vblank && hblank && (lineCnt != '0);
        rdFire    = rd_req && line_ready;
        rdNext    = rdCnt + ADDR_W'(1);
        rdRelease = rdFire && (rdNext == halfLen[rdHalf]);
    end

    assign line_ready = halfFull[rdHalf];
    assign line_len   = line_ready ? halfLen[rdHalf] : '0;
    assign rd_data    = rd_valid ? ebr_rdata : '0;

    // Write FSM with registered EBR write port and sticky overflow.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            wrState   <= StWrite;
            wrHalf    <= 1'b0;
            wrCnt     <= '0;
            ebr_we    <= 1'b0;
            ebr_waddr <= '0;
            ebr_wdata <= '0;
            overflow  <= 1'b0;
        end else begin
            ebr_we <= pixAccept;
            if (pixAccept) begin
                ebr_waddr <= {wrHalf, wrCnt[ADDR_W-2:0]};
                ebr_wdata <= pix_data;
            end
            if (vblank) begin
                wrCnt    <= '0;
                overflow <= 1'b0;
                wrState  <= halfFull[wrHalf] ? StStall : StWrite;
            end else begin
                case (wrState)
                    StWrite: begin
                        if (pix_valid && !pixAccept) overflow <= 1'b1;
                        if (commit) begin
                            wrCnt  <= '0;
                            wrHalf <= ~wrHalf;
                            if (halfFull[~wrHalf]) wrState <= StStall;
                        end else begin
                            wrCnt <= lineCnt;
                        end
                    end
                    StStall: begin
                        if (pix_valid) overflow <= 1'b1;
                        if (hblank && !halfFull[wrHalf]) wrState <= StWrite;
                    end
                    default: wrState <= StWrite;
                endcase
            end
        end
    end

    // Read side: request -> EBR enable next cycle -> data the cycle after.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            rdHalf    <= 1'b0;
            rdCnt     <= '0;
            ebr_re    <= 1'b0;
            ebr_raddr <= '0;
            rd_valid  <= 1'b0;
        end else begin
            ebr_re   <= rdFire;
            rd_valid <= ebr_re;
            if (rdFire) begin
                ebr_raddr <= {rdHalf, rdCnt[ADDR_W-2:0]};
                if (rdRelease) begin
                    rdCnt  <= '0;
                    rdHalf <= ~rdHalf;
                end else begin
                    rdCnt <= rdNext;
                end
            end
        end
    end

    // Commit and release always target different halves, so both may apply in one cycle.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            halfFull   <= 2'b00;
            halfLen[0] <= '0;
            halfLen[1] <= '0;
        end else begin
            if (rdRelease) halfFull[rdHalf] <= 1'b0;
            if (commit) begin
                halfFull[wrHalf] <= 1'b1;
                halfLen[wrHalf]  <= lineCnt;
            end
        end
    end

endmodule

// File: tb/tb_line_buf_arbiter.sv
// Randomized bench for line_buf_arbiter: a line-queue reference model predicts every output
// each cycle; a behavioural EBR sits on the memory port.
module tb_line_buf_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          rstn;
    logic          pix_valid, hblank, vblank, rd_req;
    logic [DW-1:0] pix_data;
    logic          rd_valid, line_ready, overflow, ebr_we, ebr_re;
    logic [DW-1:0] rd_data, ebr_wdata, ebr_rdata;
    logic [AW-1:0] line_len, ebr_waddr, ebr_raddr;

    line_buf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HALF_DEPTH(256)) dut (
        .pclk(pclk), .rstn(rstn), .pix_valid(pix_valid), .pix_data(pix_data),
        .hblank(hblank), .vblank(vblank), .rd_req(rd_req), .rd_valid(rd_valid),
        .rd_data(rd_data), .line_ready(line_ready), .line_len(line_len),
        .overflow(overflow), .ebr_waddr(ebr_waddr), .ebr_wdata(ebr_wdata),
        .ebr_we(ebr_we), .ebr_raddr(ebr_raddr), .ebr_re(ebr_re), .ebr_rdata(ebr_rdata)
    );

    always #5 pclk = ~pclk;

    logic [DW-1:0] mem [512];
    always @(posedge pclk) begin
        if (ebr_we) mem[ebr_waddr] <= ebr_wdata;
        if (ebr_re) ebr_rdata <= mem[ebr_raddr];
    end

    int nChecks = 0;
    int nBad = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: complete lines form a queue of at most two; bytes stream in order.
    int            lineQ[$];
    logic [DW-1:0] byteQ[$];
    logic [DW-1:0] cur[$];
    bit            stall, ovf;
    int            wrHalfM, rdHalfM, readPos;
    bit            eWe, eRe, eValid;
    int            eWaddr, eRaddr;
    logic [DW-1:0] eWdata, reByte, eData;

    task automatic modelReset();
        lineQ.delete(); byteQ.delete(); cur.delete();
        stall = 0; ovf = 0; wrHalfM = 0; rdHalfM = 0; readPos = 0;
        eWe = 0; eRe = 0; eValid = 0; eWaddr = 0; eRaddr = 0;
        eWdata = '0; reByte = '0; eData = '0;
    endtask

    task automatic modelStep();
        int sizePre = lineQ.size();
        eValid = eRe;
        eData  = reByte;
        eRe    = 0;
        if (rd_req && sizePre > 0) begin
            eRe    = 1;
            eRaddr = rdHalfM * 256 + readPos;
            reByte = byteQ.pop_front();
            readPos++;
            if (readPos == lineQ[0]) begin
                void'(lineQ.pop_front());
                readPos = 0;
                rdHalfM ^= 1;
            end
        end
        eWe = 0;
        if (vblank) begin
            cur.delete();
            ovf   = 0;
            stall = (sizePre == 2);
        end else if (stall) begin
            if (pix_valid) ovf = 1;
            if (hblank && sizePre < 2) stall = 0;
        end else begin
            if (pix_valid) begin
                if (cur.size() < 256) begin
                    eWe    = 1;
                    eWaddr = wrHalfM * 256 + cur.size();
                    eWdata = pix_data;
                    cur.push_back(pix_data);
                end else begin
                    ovf = 1;
                end
            end
            if (hblank && cur.size() > 0) begin
                lineQ.push_back(cur.size());
                foreach (cur[i]) byteQ.push_back(cur[i]);
                cur.delete();
                wrHalfM ^= 1;
                stall = (sizePre == 1);
            end
        end
    endtask

    task automatic checkAll();
        int expLen = (lineQ.size() > 0) ? lineQ[0] : 0;
        checkEq("line_ready", 32'(line_ready), 32'(lineQ.size() > 0));
        checkEq("line_len", 32'(line_len), 32'(expLen));
        checkEq("overflow", 32'(overflow), 32'(ovf));
        checkEq("ebr_we", 32'(ebr_we), 32'(eWe));
        if (eWe) begin
            checkEq("ebr_waddr", 32'(ebr_waddr), 32'(eWaddr));
            checkEq("ebr_wdata", 32'(ebr_wdata), 32'(eWdata));
        end
        checkEq("ebr_re", 32'(ebr_re), 32'(eRe));
        if (eRe) checkEq("ebr_raddr", 32'(ebr_raddr), 32'(eRaddr));
        checkEq("rd_valid", 32'(rd_valid), 32'(eValid));
        if (eValid) checkEq("rd_data", 32'(rd_data), 32'(eData));
    endtask

    task automatic checkZero();
        checkEq("rst_ebr_we", 32'(ebr_we), 0);
        checkEq("rst_ebr_re", 32'(ebr_re), 0);
        checkEq("rst_rd_valid", 32'(rd_valid), 0);
        checkEq("rst_rd_data", 32'(rd_data), 0);
        checkEq("rst_line_ready", 32'(line_ready), 0);
        checkEq("rst_line_len", 32'(line_len), 0);
        checkEq("rst_overflow", 32'(overflow), 0);
        checkEq("rst_ebr_waddr", 32'(ebr_waddr), 0);
        checkEq("rst_ebr_raddr", 32'(ebr_raddr), 0);
        checkEq("rst_ebr_wdata", 32'(ebr_wdata), 0);
    endtask

    initial begin
        int pixThr, hbThr, rdThr, vbThr;
        rstn = 1'b0; pix_valid = 0; pix_data = '0; hblank = 0; vblank = 0; rd_req = 0;
        modelReset();
        #1 checkZero();
        repeat (2) @(negedge pclk);
        rstn = 1'b1;
        for (int cyc = 0; cyc < 16000; cyc++) begin
            @(negedge pclk);
            checkAll();
            if (!rstn) rstn = 1'b1;
            if (cyc == 10000) begin
                rstn = 1'b0;
                pix_valid = 0; hblank = 0; vblank = 0; rd_req = 0;
                #1 checkZero();
                modelReset();
                continue;
            end
            case (cyc / 4000)
                0:       begin pixThr = 700; hbThr = 25; rdThr = 500; vbThr = 1; end
                1:       begin pixThr = 950; hbThr = 3;  rdThr = 800; vbThr = 0; end
                2:       begin pixThr = 800; hbThr = 60; rdThr = 50;  vbThr = 2; end
                default: begin pixThr = 850; hbThr = 16; rdThr = 1000; vbThr = 1; end
            endcase
            pix_valid = ($urandom_range(0, 999) < pixThr);
            pix_data  = DW'($urandom_range(0, 255));
            hblank    = ($urandom_range(0, 999) < hbThr);
            vblank    = ($urandom_range(0, 999) < vbThr);
            rd_req    = ($urandom_range(0, 999) < rdThr);
            modelStep();
        end
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
